// File: rtl/cdr_bbpd_voter.sv
// Bang-bang (Alexander) phase detector with optional majority voting over
// VOTE_LEN bit slots; drives registered Up/Dn pulses into the loop filter.
module cdr_bbpd_voter #(
    parameter int VOTE_LEN = 8,
    parameter int THRESH   = 2,
    parameter int NW       = $clog2(VOTE_LEN) + 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          vote_en,
    input  logic          data_smp,
    input  logic          edge_smp,
    output logic          Up,
    output logic          Dn,
    output logic [NW-1:0] net_dbg
);

    localparam int WW = (VOTE_LEN > 1) ? $clog2(VOTE_LEN) : 1;
    localparam logic [WW-1:0]        WIN_LAST = WW'(VOTE_LEN - 1);
    localparam logic signed [NW-1:0] TH_POS   = NW'(THRESH);
    localparam logic signed [NW-1:0] TH_NEG   = NW'(-THRESH);
    localparam logic signed [NW-1:0] ONE      = NW'(1);

    // sample pipe: A = a_q (previous bit), T = e_q, B = d_q (current bit)
    logic d_q, e_q, a_q;
    logic [1:0] fill;
    logic [WW-1:0] win_cnt;
    logic signed [NW-1:0] acc;
    logic vote_q;

    logic valid, trans, late, early, win_end, vote_chg;
    logic signed [NW-1:0] contrib, net;

    logic up_nxt, dn_nxt;
    logic [1:0] fill_nxt;
    logic [WW-1:0] win_nxt;
    logic signed [NW-1:0] acc_nxt;
    logic [NW-1:0] net_nxt;

    always_comb begin
        valid    = (fill == 2'd2);
        trans    = a_q ^ d_q;
        late     = valid & trans & (e_q == d_q);
        early    = valid & trans & (e_q == a_q);
        contrib  = late ? ONE : (early ? -ONE : '0);
        net      = acc + contrib;
        win_end  = valid && (win_cnt == WIN_LAST);
        vote_chg = vote_en ^ vote_q;
    end

    always_comb begin
        up_nxt   = 1'b0;
        dn_nxt   = 1'b0;
        fill_nxt = fill;
        win_nxt  = win_cnt;
        acc_nxt  = acc;
        net_nxt  = net_dbg;
        if (!en) begin
            fill_nxt = 2'd0;
            win_nxt  = '0;
            acc_nxt  = '0;
        end else begin
            if (fill != 2'd2)
                fill_nxt = fill + 2'd1;
            // a mode switch throws away whatever partial window was in flight
            if (vote_chg) begin
                win_nxt = '0;
                acc_nxt = '0;
            end else if (!vote_en) begin
                up_nxt  = late;
                dn_nxt  = early;
                win_nxt = '0;
                acc_nxt = '0;
            end else if (valid) begin
                if (win_end) begin
                    up_nxt  = (net >= TH_POS);
                    dn_nxt  = (net <= TH_NEG);
                    net_nxt = net;
                    win_nxt = '0;
                    acc_nxt = '0;
                end else begin
                    win_nxt = win_cnt + WW'(1);
                    acc_nxt = net;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q     <= 1'b0;
            e_q     <= 1'b0;
            a_q     <= 1'b0;
            fill    <= 2'd0;
            win_cnt <= '0;
            acc     <= '0;
            vote_q  <= 1'b0;
            Up      <= 1'b0;
            Dn      <= 1'b0;
            net_dbg <= '0;
        end else begin
            if (en) begin
                d_q <= data_smp;
                e_q <= edge_smp;
                a_q <= d_q;
            end
            fill    <= fill_nxt;
            win_cnt <= win_nxt;
            acc     <= acc_nxt;
            vote_q  <= vote_en;
            Up      <= up_nxt;
            Dn      <= dn_nxt;
            net_dbg <= net_nxt;
        end
    end

endmodule

// File: tb/tb_cdr_bbpd_voter.sv
// Directed bench for cdr_bbpd_voter: bypass, voting, thresholds, interrupts, reset.
module tb_cdr_bbpd_voter;

    localparam int NW = 5;

    logic clk = 1'b0;
    logic rst_n, en, vote_en, data_smp, edge_smp;
    logic Up, Dn;
    logic [NW-1:0] net_dbg;

    int n_cmp = 0;
    int n_bad = 0;
    logic prv;

    typedef enum logic [1:0] {LATE, EARLY, NONE} cls_t;

    cls_t pat [0:23] = '{LATE, LATE, LATE, EARLY, EARLY, NONE, NONE, NONE,
                         LATE, LATE, LATE, LATE, EARLY, EARLY, NONE, NONE,
                         LATE, LATE, EARLY, EARLY, EARLY, EARLY, NONE, NONE};

    always #5 clk = ~clk;

    cdr_bbpd_voter #(.VOTE_LEN(8), .THRESH(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .vote_en(vote_en),
        .data_smp(data_smp), .edge_smp(edge_smp),
        .Up(Up), .Dn(Dn), .net_dbg(net_dbg)
    );

    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
        end
    endtask

    // each slot is classified relative to the previously driven data bit
    task automatic drive(input cls_t c);
        case (c)
            LATE:    begin data_smp = ~prv; edge_smp = ~prv; end
            EARLY:   begin data_smp = ~prv; edge_smp = prv;  end
            default: begin data_smp = prv;  edge_smp = ~prv; end
        endcase
        prv = data_smp;
        @(posedge clk);
        #1;
    endtask

    task automatic slot(input string tag, input cls_t c, input logic eu, input logic ed);
        drive(c);
        check({tag, "_up"}, Up, eu);
        check({tag, "_dn"}, Dn, ed);
    endtask

    task automatic restart(input logic v);
        en = 1'b0;
        vote_en = v;
        @(posedge clk);
        #1;
        check("restart_up", Up, 0);
        check("restart_dn", Dn, 0);
        en = 1'b1;
    endtask

    task automatic net_chk(input string tag, input logic signed [31:0] exp);
        check(tag, $signed(net_dbg), exp);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b1; vote_en = 1'b0;
        data_smp = 1'b0; edge_smp = 1'b0; prv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_up", Up, 0);
        check("rst_dn", Dn, 0);
        net_chk("rst_net", 0);
        rst_n = 1'b1;

        // bypass: two fill edges, then Up on every late slot
        slot("byp_fill", LATE, 0, 0);
        slot("byp_fill", LATE, 0, 0);
        repeat (6) slot("byp_late", LATE, 1, 0);
        slot("byp_e1", EARLY, 1, 0);
        slot("byp_e2", EARLY, 0, 1);
        slot("byp_n1", NONE, 0, 1);
        slot("byp_n2", NONE, 0, 0);

        // voting, all early: Dn every 8 slots
        restart(1'b1);
        drive(NONE);
        for (int i = 0; i <= 16; i++) begin
            slot("vote_early", EARLY, 0, (i == 8 || i == 16));
            if (i == 8) net_chk("vote_early_net", -8);
        end

        // threshold boundaries: +1 (none), +2 (Up), -2 (Dn)
        restart(1'b1);
        drive(NONE);
        for (int i = 0; i < 24; i++) begin
            slot("thr", pat[i], (i == 16), 0);
            if (i == 8)  net_chk("thr_net_p1", 1);
            if (i == 16) net_chk("thr_net_p2", 2);
        end
        slot("thr_dn", NONE, 0, 1);
        net_chk("thr_net_m2", -2);

        // no transitions on constant 1 data
        restart(1'b1);
        prv = 1'b1;
        drive(NONE);
        for (int i = 0; i <= 32; i++) begin
            slot("flat", NONE, 0, 0);
            if (i > 0 && i % 8 == 0) net_chk("flat_net", 0);
        end

        // en drop mid-window, then full refill before the next pulse
        restart(1'b1);
        drive(NONE);
        repeat (5) slot("en_pre", LATE, 0, 0);
        restart(1'b1);
        drive(NONE);
        for (int i = 0; i <= 8; i++) begin
            slot("en_refill", LATE, (i == 8), 0);
            if (i == 8) net_chk("en_refill_net", 8);
        end

        // vote_en toggle mid-window discards the partial window
        restart(1'b1);
        drive(NONE);
        repeat (5) slot("tog_pre", LATE, 0, 0);
        vote_en = 1'b0;
        drive(LATE);
        vote_en = 1'b1;
        drive(LATE);
        for (int i = 0; i < 8; i++) begin
            slot("tog", LATE, (i == 7), 0);
            if (i == 7) net_chk("tog_net", 8);
        end

        // asynchronous reset in the middle of bypass traffic
        vote_en = 1'b0;
        drive(LATE);
        slot("rst_mid_pre", LATE, 1, 0);
        rst_n = 1'b0;
        #1;
        check("rst_mid_up", Up, 0);
        check("rst_mid_dn", Dn, 0);
        net_chk("rst_mid_net", 0);
        rst_n = 1'b1;
        slot("rst_refill1", LATE, 0, 0);
        slot("rst_refill2", LATE, 0, 0);
        slot("rst_refill3", LATE, 1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cdr_bbpd_voter.md
# cdr_bbpd_voter

Bang-bang (Alexander) phase detector with majority voting for the CDR loop. Registers the per-bit data and edge samples, classifies each bit slot as early, late or no-transition, and produces the Up/Dn pulses that drive the digital loop filter directly downstream. Supports per-bit (bypass) output or windowed voting to cut filter update rate and pattern-induced jitter.

## Interface
- VOTE_LEN, 8: bit slots per voting window; 2..64.
- THRESH, 2: minimum |net| (late − early) for a window to emit a pulse; 1..VOTE_LEN.
- NW, $clog2(VOTE_LEN)+2: signed width of the net accumulator and net_dbg.

- clk  in  1  recovered clock, one bit slot per cycle
- rst_n  in  1  reset, asynchronous, active-low
- en  in  1  detector enable
- vote_en  in  1  1 = windowed voting, 0 = per-bit bypass; quasi-static
- data_smp  in  1  data sample of current bit (B)
- edge_smp  in  1  edge sample between previous and current bit (T)
- Up  out  1  late indication to loop filter (clock late, advance phase)
- Dn  out  1  early indication to loop filter
- net_dbg  out  NW  signed net of the last completed window

## Operation
- Input stage, each enabled edge: d_q <= data_smp, e_q <= edge_smp, a_q <= d_q. A = a_q, T = e_q, B = d_q.
- Valid tracking: 2-bit fill counter, saturating. Decision valid only when fill = 2, i.e. both a_q and d_q hold enabled samples.
- Classification (valid only): A == B → none. A != B and T == A → early. A != B and T == B → late. Late and early are mutually exclusive.
- Bypass (vote_en = 0): Up <= late, Dn <= early each cycle. net_dbg holds its value.
- Voting (vote_en = 1):
  - win_cnt counts valid slots 0..VOTE_LEN-1 and wraps. No-transition slots count.
  - acc is a signed NW-bit register: +1 on late, −1 on early. It cannot overflow because |acc| ≤ VOTE_LEN.
  - On the slot where win_cnt = VOTE_LEN-1, evaluate net = acc + this slot's contribution:
    - Up <= (net >= THRESH).
    - Dn <= (net <= −THRESH).
    - net_dbg <= net.
    - acc <= 0, win_cnt <= 0.
  - All other cycles: Up <= 0, Dn <= 0.
- en = 0, next edge:
  - Up, Dn <= 0.
  - fill, win_cnt, acc <= 0.
  - Input registers hold.
  - net_dbg holds.
- vote_en change, detected against a registered copy: win_cnt and acc clear on the following edge. The partial window is discarded and no pulse is emitted for it.
- Invariant: Up & Dn is never 1.

## Timing
- Reset values: Up = 0, Dn = 0, net_dbg = 0, acc = 0, win_cnt = 0, fill = 0, d_q/e_q/a_q = 0.
- Bypass latency: samples presented at edge k are classified from registers after edge k. Up/Dn reflect them after edge k+1, i.e. 2 cycles input-to-output.
- First decision after reset release or en rise:
  - Samples at enabled edges 1 and 2 fill the pipe.
  - The first valid Up/Dn appears after edge 3.
- Voting: a pulse is exactly one cycle wide. With continuous valid input, pulses are separated by VOTE_LEN cycles. The pulse follows the window's last bit with the same 2-cycle latency as bypass.
- Reset asserted mid-window: all state clears asynchronously. The first full window restarts after the pipe refills.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert rst_n = 0 mid-traffic → Up = Dn = 0 and net_dbg = 0 immediately. After release, no output before the 3rd enabled edge.
- Bypass late: vote_en = 0, data alternating 0,1,0,1, edge_smp = data_smp → Up = 1 every cycle from the 3rd edge onward, Dn = 0.
- Voting early: VOTE_LEN = 8, THRESH = 2, alternating data, edge_smp = previous data → single-cycle Dn pulse every 8 cycles, Up = 0, net_dbg = −8.
- Threshold boundaries in one window:
  - 3 late, 2 early, 3 none → no pulse, net_dbg = +1.
  - Next window, 4 late, 2 early → Up pulse, net_dbg = +2.
  - Next window, 2 late, 4 early → Dn pulse, net_dbg = −2.
- No transitions: constant data = 1 for 32 cycles with vote_en = 1 → no Up/Dn, net_dbg = 0 after each window.
- Interrupts:
  - en drops after 5 slots of an all-late window → Up = Dn = 0 next edge. After en returns, the first pulse arrives 2 (refill) + 8 slots later, not early.
  - A vote_en toggle mid-window discards the partial window the same way.
